// File: rtl/uart_pkg.sv
// Shared UART framing constants and the register-dump sequencer state encoding.
package uart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = DATA_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_LATCH,
    ST_SEND,
    ST_NEXT,
    ST_FIN
  } dump_state_t;

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte transmitter: one start bit, eight data bits LSB first, one stop bit,
// each held for CLKS_PER_BIT cycles. done marks the final cycle of the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(FRAME_BITS - 1);

  logic                  active_reg, active_next;
  logic [CW-1:0]         baud_reg, baud_next;
  logic [3:0]            bit_reg, bit_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic                  tx_reg, tx_next;
  logic [FRAME_BITS-1:0] frame;
  logic                  bit_end;
  logic                  last_bit;

  assign frame[0]            = START_BIT;
  assign frame[FRAME_BITS-1] = STOP_BIT;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_frame
      assign frame[gi+1] = data[gi];
    end
  endgenerate

  assign bit_end  = (baud_reg == BAUD_LAST);
  assign last_bit = (bit_reg == BIT_LAST);

  always_comb begin
    active_next = active_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    tx_next     = tx_reg;
    if (!active_reg) begin
      if (send) begin
        active_next = 1'b1;
        baud_next   = '0;
        bit_next    = '0;
        shift_next  = frame;
        tx_next     = frame[0];
      end
    end else if (bit_end) begin
      baud_next = '0;
      if (last_bit) begin
        active_next = 1'b0;
        tx_next     = STOP_BIT;
      end else begin
        // shift_reg[0] always mirrors the bit currently on the line
        bit_next   = bit_reg + 4'd1;
        shift_next = {STOP_BIT, shift_reg[FRAME_BITS-1:1]};
        tx_next    = shift_reg[1];
      end
    end else begin
      baud_next = baud_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= 1'b0;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '1;
      tx_reg     <= 1'b1;
    end else begin
      active_reg <= active_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
    end
  end

  assign tx    = tx_reg;
  assign ready = !active_reg;
  assign done  = active_reg && bit_end && last_bit;

endmodule

// File: rtl/uart_reg_dump.sv
// Walks the register-file debug port and streams a header byte followed by
// every register word (MSB byte first) over an 8N1 UART line.
module uart_reg_dump
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         NREGS        = 32,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  uart_ra,
  input  logic [31:0] uart_rd,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  dump_state_t state_reg, state_next;
  logic [4:0]  ridx_reg, ridx_next;
  logic [1:0]  bidx_reg, bidx_next;
  logic [31:0] word_reg, word_next;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_done;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .send (tx_send),
    .data (tx_data),
    .tx   (tx),
    .ready(tx_ready),
    .done (tx_done)
  );

  always_comb begin
    state_next = state_reg;
    ridx_next  = ridx_reg;
    bidx_next  = bidx_reg;
    word_next  = word_reg;
    tx_send    = 1'b0;
    tx_data    = HEADER;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_HDR;
          ridx_next  = '0;
        end
      end
      ST_HDR: begin
        // ready drops as soon as the byte is taken, so this issues exactly once
        tx_send = tx_ready;
        if (tx_done) state_next = ST_ADDR;
      end
      ST_ADDR: state_next = ST_LATCH;
      ST_LATCH: begin
        word_next  = uart_rd;
        bidx_next  = 2'd3;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        tx_send = tx_ready;
        tx_data = word_byte(word_reg, bidx_reg);
        if (tx_done) begin
          if (bidx_reg != 2'd0) bidx_next = bidx_reg - 2'd1;
          else                  state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (ridx_reg == LAST_IDX) begin
          state_next = ST_FIN;
        end else begin
          ridx_next  = ridx_reg + 5'd1;
          state_next = ST_ADDR;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ridx_reg  <= '0;
      bidx_reg  <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ridx_reg  <= ridx_next;
      bidx_reg  <= bidx_next;
      word_reg  <= word_next;
    end
  end

  assign uart_ra = {1'b0, ridx_reg};
  assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
  assign done    = (state_reg == ST_FIN);

endmodule

// File: tb/tb_uart_reg_dump.sv
// Directed bench for uart_reg_dump: a UART line decoder feeds a byte scoreboard,
// with a register-file model answering the debug read port.
module tb_uart_reg_dump;

  localparam int CPB = 4;

  logic        clk;
  logic        reset_a, start_a, reset_b, start_b;
  logic [5:0]  ra_a, ra_b;
  logic [31:0] rd_a, rd_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_bytes = 0;
  int          prev_start = -1;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  int          done_cyc_b = 0;
  logic        bprev_a = 1'b0;
  logic        bprev_b = 1'b0;
  logic        mon_sel = 1'b0;
  logic        mon_tx, mon_rst;
  logic [7:0]  exp_q[$];

  function automatic logic [31:0] rf_model(input logic [5:0] a);
    return (a == 6'd0) ? 32'h0 : 32'h1000_0000 + {26'd0, a};
  endfunction

  assign rd_a    = rf_model(ra_a);
  assign rd_b    = rf_model(ra_b);
  assign mon_tx  = mon_sel ? tx_b : tx_a;
  assign mon_rst = mon_sel ? reset_b : reset_a;

  uart_reg_dump #(.CLKS_PER_BIT(CPB), .NREGS(32), .HEADER(8'hA5)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .uart_ra(ra_a), .uart_rd(rd_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_reg_dump #(.CLKS_PER_BIT(CPB), .NREGS(1), .HEADER(8'h3C)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .uart_ra(ra_b), .uart_rd(rd_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples every bit cell on negedges and pops the scoreboard per byte.
  initial begin : uart_mon
    logic [7:0] rx;
    logic [7:0] want;
    bit         ok, abort;
    int         s, delta;
    forever begin
      @(negedge clk);
      if (mon_rst === 1'b0 && mon_tx === 1'b0) begin
        s = cyc; ok = 1'b1; abort = 1'b0; rx = '0;
        for (int k = 1; k < CPB && !abort; k++) begin
          @(negedge clk);
          if (mon_rst !== 1'b0) abort = 1'b1;
          else if (mon_tx !== 1'b0) ok = 1'b0;
        end
        for (int bi = 0; bi < 8 && !abort; bi++) begin
          for (int k = 0; k < CPB && !abort; k++) begin
            @(negedge clk);
            if (mon_rst !== 1'b0) abort = 1'b1;
            else if (k == 0) rx[bi] = mon_tx;
            else if (mon_tx !== rx[bi]) ok = 1'b0;
          end
        end
        for (int k = 0; k < CPB && !abort; k++) begin
          @(negedge clk);
          if (mon_rst !== 1'b0) abort = 1'b1;
          else if (mon_tx !== 1'b1) ok = 1'b0;
        end
        if (abort) begin
          prev_start = -1;
        end else begin
          n_vec++;
          assert (ok) else begin
            n_err++;
            $error("FAIL bit_timing: byte %0d (%02h) observed uneven bit cells, required %0d cycles per bit", n_bytes, rx, CPB);
          end
          if (prev_start >= 0) begin
            delta = s - prev_start;
            n_vec++;
            assert (delta >= 10*CPB && delta <= 10*CPB + 5) else begin
              n_err++;
              $error("FAIL byte_period: byte %0d observed %0d cycles, required %0d..%0d", n_bytes, delta, 10*CPB, 10*CPB + 5);
            end
          end
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL unexpected_byte: observed %02h, required no byte", rx);
          end else begin
            want = exp_q.pop_front();
            assert (rx === want) else begin
              n_err++;
              $error("FAIL byte_%0d: observed %02h, expected %02h", n_bytes, rx, want);
            end
          end
          prev_start = s;
          n_bytes++;
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        done_cnt_a++;
        n_vec++;
        assert (busy_a === 1'b0 && bprev_a === 1'b1) else begin
          n_err++;
          $error("FAIL done_busy_a: busy=%b prev_busy=%b, required 0 and 1", busy_a, bprev_a);
        end
      end
      if (done_b === 1'b1) begin
        done_cnt_b++;
        done_cyc_b = cyc;
        n_vec++;
        assert (busy_b === 1'b0 && bprev_b === 1'b1) else begin
          n_err++;
          $error("FAIL done_busy_b: busy=%b prev_busy=%b, required 0 and 1", busy_b, bprev_b);
        end
      end
      bprev_a = busy_a;
      bprev_b = busy_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] hdr, input int nregs);
    logic [31:0] w;
    exp_q.push_back(hdr);
    for (int r = 0; r < nregs; r++) begin
      w = (r == 0) ? 32'h0 : 32'h1000_0000 + 32'(r);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (n_bytes < n && k < budget) begin tick(); k++; end
    check("wait_bytes", n_bytes >= n, 1);
  endtask

  task automatic wait_tx_low_a(input int budget);
    int k = 0;
    while (tx_a !== 1'b0 && k < budget) begin tick(); k++; end
    check("wait_tx_low", tx_a, 0);
  endtask

  task automatic wait_done_a(input int d0, input int budget);
    int k = 0;
    while (done_cnt_a == d0 && k < budget) begin tick(); k++; end
    check("wait_done_a", done_cnt_a != d0, 1);
  endtask

  task automatic idle_a(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_idle_busy"}, busy_a, 0);
      check({tag, "_idle_tx"}, tx_a, 1);
    end
  endtask

  task automatic full_frame_a(input string tag, input bit repulse);
    int d0;
    d0 = done_cnt_a; n_bytes = 0; prev_start = -1;
    push_frame(8'hA5, 32);
    pulse_a();
    check({tag, "_busy_rise"}, busy_a, 1);
    if (repulse) begin
      wait_bytes(1, 500);    pulse_a();
      wait_bytes(60, 4000);  pulse_a();
      wait_bytes(128, 4000); pulse_a();
    end
    wait_done_a(d0, 7000);
    repeat (3) tick();
    check({tag, "_bytes"}, n_bytes, 129);
    check({tag, "_done_cnt"}, done_cnt_a - d0, 1);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    idle_a(tag, 20);
  endtask

  initial begin : stim
    int d0, t0, k, delta;
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) tick();
    reset_a = 1'b0; reset_b = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 50; i++) begin
      tick();
      check("s1_tx", tx_a, 1);
      check("s1_busy", busy_a, 0);
      check("s1_done", done_a, 0);
      check("s1_ra", {26'd0, ra_a}, 0);
    end
    check("s1_no_bytes", n_bytes, 0);

    // 2/3: one full dump
    full_frame_a("s2", 1'b0);

    // 4: start re-pulsed while busy
    full_frame_a("s4", 1'b1);

    // 5: reset during the header start bit
    d0 = done_cnt_a; n_bytes = 0; prev_start = -1;
    push_frame(8'hA5, 32);
    pulse_a();
    wait_tx_low_a(50);
    tick();
    reset_a = 1'b1;
    tick();
    check("s5a_tx", tx_a, 1);
    check("s5a_busy", busy_a, 0);
    reset_a = 1'b0;
    exp_q.delete();
    tick();
    check("s5a_bytes", n_bytes, 0);

    // 5: reset during data bit 5 of word 7's first byte
    n_bytes = 0; prev_start = -1;
    push_frame(8'hA5, 32);
    pulse_a();
    wait_bytes(29, 2000);
    wait_tx_low_a(20);
    repeat (24) tick();
    reset_a = 1'b1;
    tick();
    check("s5b_tx", tx_a, 1);
    check("s5b_busy", busy_a, 0);
    check("s5b_ra", {26'd0, ra_a}, 0);
    reset_a = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    check("s5b_bytes", n_bytes, 29);
    check("s5_no_done", done_cnt_a - d0, 0);
    full_frame_a("s5c", 1'b0);

    // 6: single-register instance with its own header
    mon_sel = 1'b1;
    d0 = done_cnt_b; n_bytes = 0; prev_start = -1;
    push_frame(8'h3C, 1);
    t0 = cyc;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    k = 0;
    while (done_cnt_b == d0 && k < 400) begin tick(); k++; end
    check("s6_done_seen", done_cnt_b != d0, 1);
    repeat (3) tick();
    check("s6_bytes", n_bytes, 5);
    check("s6_done_cnt", done_cnt_b - d0, 1);
    check("s6_queue_left", exp_q.size(), 0);
    delta = done_cyc_b - t0;
    n_vec++;
    assert (delta >= 200 && delta <= 215) else begin
      n_err++;
      $error("FAIL s6_latency: observed %0d cycles, required 200..215", delta);
    end
    check("s6_busy_end", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
